// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the LFSR-based random draw unit.
// lfsr_next works on a fixed maximum width so any core width up to LFSR_MAX_W-1 can reuse it.
package lfsr_pkg;

   localparam int LFSR_MAX_W = 64;

   localparam logic [10:0] TAPS_11 = 11'h005;
   localparam logic [15:0] TAPS_16 = 16'hA011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DRAW = 2'd1,
      ST_HOLD = 2'd2
   } gen_state_e;

   // XNOR feedback into the top bit, shift right by one; bits above width stay zero
   function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
      input logic [LFSR_MAX_W-1:0] d,
      input logic [LFSR_MAX_W-1:0] taps,
      input int                    width
   );
      logic                  fb;
      logic [LFSR_MAX_W-1:0] nxt;
      fb  = ~(^(d & taps));
      nxt = {1'b0, d[LFSR_MAX_W-1:1]} | ({{(LFSR_MAX_W-1){1'b0}}, fb} << (width - 1));
      return nxt;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR state register with feedback and all-ones lock-up substitution on load.
// Priority: reset, then load, then step; the state holds otherwise.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] TAPS  = 16'hA011,
   parameter logic [WIDTH-1:0] SEED  = 16'h0ACE
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] d
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   logic [WIDTH-1:0]      d_r;
   logic [WIDTH-1:0]      step_val_s;
   logic [WIDTH-1:0]      load_safe_s;
   logic [LFSR_MAX_W-1:0] next_full_s;
   logic                  unused_hi_s;

   // next-state and lock-up-safe load value
   always_comb begin
      next_full_s = lfsr_next(LFSR_MAX_W'(d_r), LFSR_MAX_W'(TAPS), WIDTH);
      step_val_s  = next_full_s[WIDTH-1:0];
      unused_hi_s = ^next_full_s[LFSR_MAX_W-1:WIDTH];
      if (load_val == ALL_ONES) begin
         load_safe_s = SEED;
      end else begin
         load_safe_s = load_val;
      end
   end

   // state register
   always_ff @(posedge clk) begin
      if (reset) begin
         d_r <= SEED;
      end else if (load) begin
         d_r <= load_safe_s;
      end else if (step) begin
         d_r <= step_val_s;
      end else begin
         d_r <= d_r;
      end
   end

   assign d = d_r;

endmodule

// File: rtl/lfsr_rand_gen_checker.sv
// Simulation-only property checks for lfsr_rand_gen: parameter legality, output range,
// LFSR lock-up avoidance and output stability under backpressure.
module lfsr_rand_gen_checker
   import lfsr_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hA011,
   parameter logic [WIDTH-1:0] SEED      = 16'h0ACE,
   parameter int               RANGE     = 4,
   parameter int               MAX_TRIES = 4,
   parameter int               OUT_BITS  = 2
) (
   input logic                clk,
   input logic                reset,
   input logic                out_ready,
   input logic                out_valid,
   input logic [OUT_BITS-1:0] rnd,
   input logic [WIDTH-1:0]    d
);

   localparam logic [WIDTH-1:0]  ALL_ONES  = {WIDTH{1'b1}};
   localparam logic [OUT_BITS:0] RANGE_EXT = (OUT_BITS + 1)'(RANGE);
   localparam bit PARAMS_OK = (WIDTH >= 2) && (WIDTH < LFSR_MAX_W) &&
                              ((^TAPS) == 1'b0) && (SEED != ALL_ONES) &&
                              (RANGE >= 1) && (longint'(RANGE) <= (64'sd1 <<< WIDTH)) &&
                              (MAX_TRIES >= 1) && (OUT_BITS <= WIDTH);

   logic                hold_prev_r;
   logic [OUT_BITS-1:0] rnd_prev_r;

   // remember whether the last cycle was a stalled valid output
   always_ff @(posedge clk) begin
      hold_prev_r <= out_valid && !out_ready && !reset;
      rnd_prev_r  <= rnd;
   end

   // invariant checks
   always @(posedge clk) begin
      if (!reset) begin
         assert (PARAMS_OK) else $error("lfsr_rand_gen: illegal parameter set");
         assert (d != ALL_ONES) else $error("lfsr_rand_gen: LFSR reached lock-up state");
         if (out_valid) begin
            assert ({1'b0, rnd} < RANGE_EXT) else $error("lfsr_rand_gen: rnd out of range");
         end
         if (hold_prev_r && out_valid) begin
            assert (rnd == rnd_prev_r) else $error("lfsr_rand_gen: rnd changed while stalled");
         end
      end
   end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Uniform random draw over 0..RANGE-1 from an LFSR, using bounded rejection sampling
// and a req/valid/ready handshake; supports run-time reseeding.
module lfsr_rand_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] TAPS      = 16'hA011,
   parameter logic [WIDTH-1:0] SEED      = 16'h0ACE,
   parameter int               RANGE     = 4,
   parameter int               MAX_TRIES = 4,
   localparam int              OUT_BITS  = (RANGE > 1) ? $clog2(RANGE) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                out_ready,
   input  logic                seed_load,
   input  logic [WIDTH-1:0]    seed_in,
   output logic                out_valid,
   output logic [OUT_BITS-1:0] rnd,
   output logic                busy
);

   localparam int                  TRY_BITS  = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [TRY_BITS-1:0] TRY_LAST  = TRY_BITS'(MAX_TRIES - 1);
   localparam logic [TRY_BITS-1:0] TRY_ONE   = TRY_BITS'(32'd1);
   localparam logic [TRY_BITS-1:0] TRY_ZERO  = {TRY_BITS{1'b0}};
   localparam logic [OUT_BITS:0]   RANGE_EXT = (OUT_BITS + 1)'(RANGE);
   localparam logic [OUT_BITS-1:0] RANGE_LOW = OUT_BITS'(RANGE);
   localparam logic [OUT_BITS-1:0] RND_ZERO  = {OUT_BITS{1'b0}};

   gen_state_e          state_r;
   logic [TRY_BITS-1:0] try_cnt_r;
   logic                out_valid_r;
   logic [OUT_BITS-1:0] rnd_r;
   logic                busy_r;

   logic [WIDTH-1:0]    d_s;
   logic                step_s;
   logic [OUT_BITS-1:0] cand_s;
   logic                cand_ok_s;

   lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .step     (step_s),
      .load     (seed_load),
      .load_val (seed_in),
      .d        (d_s)
   );

   // candidate from the pre-step state; the LFSR advances on every DRAW cycle
   always_comb begin
      step_s    = (state_r == ST_DRAW);
      cand_s    = d_s[OUT_BITS-1:0];
      cand_ok_s = ({1'b0, cand_s} < RANGE_EXT);
   end

   // draw FSM, retry counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         try_cnt_r   <= TRY_ZERO;
         out_valid_r <= 1'b0;
         rnd_r       <= RND_ZERO;
         busy_r      <= 1'b0;
      end else if (seed_load) begin
         state_r     <= ST_IDLE;
         try_cnt_r   <= TRY_ZERO;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_valid_r <= 1'b0;
               if (req) begin
                  state_r   <= ST_DRAW;
                  try_cnt_r <= TRY_ZERO;
                  busy_r    <= 1'b1;
               end else begin
                  busy_r    <= 1'b0;
               end
            end
            ST_DRAW: begin
               if (cand_ok_s) begin
                  rnd_r       <= cand_s;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_HOLD;
               end else if (try_cnt_r == TRY_LAST) begin
                  // cand < 2^OUT_BITS <= 2*RANGE, so the folded value is in range
                  rnd_r       <= cand_s - RANGE_LOW;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_HOLD;
               end else begin
                  try_cnt_r   <= try_cnt_r + TRY_ONE;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  if (req) begin
                     state_r   <= ST_DRAW;
                     try_cnt_r <= TRY_ZERO;
                  end else begin
                     state_r   <= ST_IDLE;
                     busy_r    <= 1'b0;
                  end
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               try_cnt_r   <= TRY_ZERO;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign rnd       = rnd_r;
   assign busy      = busy_r;

   lfsr_rand_gen_checker #(
      .WIDTH     (WIDTH),
      .TAPS      (TAPS),
      .SEED      (SEED),
      .RANGE     (RANGE),
      .MAX_TRIES (MAX_TRIES),
      .OUT_BITS  (OUT_BITS)
   ) u_checker (
      .clk       (clk),
      .reset     (reset),
      .out_ready (out_ready),
      .out_valid (out_valid_r),
      .rnd       (rnd_r),
      .d         (d_s)
   );

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// Directed bench for lfsr_rand_gen: latency, rejection, fallback, backpressure,
// reseeding, reset, full period (11-bit) and output distribution (defaults).
module tb_lfsr_rand_gen;

   localparam logic [10:0] SEED11 = 11'b01010100111;

   logic        clk = 1'b0;
   logic        reset, req, out_ready, seed_load;
   logic [10:0] seed_in;
   logic [15:0] seed_in_d;
   logic        valid_a, valid_b, valid_c, valid_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic [1:0]  rnd_a, rnd_b, rnd_c, rnd_d;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lfsr_rand_gen #(.WIDTH(11), .TAPS(11'h005), .SEED(SEED11), .RANGE(4), .MAX_TRIES(4)) u_a (
      .clk(clk), .reset(reset), .req(req), .out_ready(out_ready), .seed_load(seed_load),
      .seed_in(seed_in), .out_valid(valid_a), .rnd(rnd_a), .busy(busy_a));

   lfsr_rand_gen #(.WIDTH(11), .TAPS(11'h005), .SEED(SEED11), .RANGE(3), .MAX_TRIES(4)) u_b (
      .clk(clk), .reset(reset), .req(req), .out_ready(out_ready), .seed_load(seed_load),
      .seed_in(seed_in), .out_valid(valid_b), .rnd(rnd_b), .busy(busy_b));

   lfsr_rand_gen #(.WIDTH(11), .TAPS(11'h005), .SEED(SEED11), .RANGE(3), .MAX_TRIES(2)) u_c (
      .clk(clk), .reset(reset), .req(req), .out_ready(out_ready), .seed_load(seed_load),
      .seed_in(seed_in), .out_valid(valid_c), .rnd(rnd_c), .busy(busy_c));

   lfsr_rand_gen u_d (
      .clk(clk), .reset(reset), .req(req), .out_ready(out_ready), .seed_load(seed_load),
      .seed_in(seed_in_d), .out_valid(valid_d), .rnd(rnd_d), .busy(busy_d));

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] step11(input logic [10:0] v);
      return {~(v[0] ^ v[2]), v[10:1]};
   endfunction

   initial begin
      int          lat_a, lat_b, lat_c;
      int          got, n, err, early, nd;
      int          cnt [4];
      logic        stable;
      logic [10:0] snap, m;

      lat_a = 0; lat_b = 0; lat_c = 0;
      reset = 1'b1; req = 1'b0; out_ready = 1'b0; seed_load = 1'b0;
      seed_in = 11'h000; seed_in_d = 16'h1234;
      cyc(); cyc();
      chk("rst_valid", 32'(valid_a), 32'd0);
      chk("rst_rnd",   32'(rnd_a),   32'd0);
      chk("rst_busy",  32'(busy_a),  32'd0);
      chk("rst_d",     32'(u_a.u_core.d), 32'(SEED11));
      reset = 1'b0;
      cyc();

      // one request, observe latency on all three 11-bit variants
      req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         req = 1'b0;
         if (valid_a && lat_a == 0) lat_a = i;
         if (valid_b && lat_b == 0) lat_b = i;
         if (valid_c && lat_c == 0) lat_c = i;
      end
      chk("lat_direct",   32'(lat_a), 32'd2);
      chk("rnd_direct",   32'(rnd_a), 32'd3);
      chk("lat_reject",   32'(lat_b), 32'd4);
      chk("rnd_reject",   32'(rnd_b), 32'd1);
      chk("lat_fallback", 32'(lat_c), 32'd3);
      chk("rnd_fallback", 32'(rnd_c), 32'd0);
      chk("busy_hold",    32'(busy_a), 32'd1);

      // backpressure: req high, ready low for 10 cycles
      snap   = u_a.u_core.d;
      chk("bp_d_one_step", 32'(snap), 32'(step11(SEED11)));
      stable = 1'b1;
      req    = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (!(valid_a === 1'b1 && rnd_a === 2'd3 && u_a.u_core.d === snap)) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      out_ready = 1'b1;
      cyc();
      chk("b2b_gap_valid", 32'(valid_a), 32'd0);
      chk("b2b_gap_busy",  32'(busy_a),  32'd1);
      req = 1'b0;
      cyc();
      chk("b2b_valid", 32'(valid_a), 32'd1);
      chk("b2b_rnd",   32'(rnd_a),   32'd3);
      cyc();
      chk("b2b_idle_busy", 32'(busy_a), 32'd0);

      // reseed with all-ones while in DRAW
      req = 1'b1;
      cyc();
      chk("sl_pre_busy", 32'(busy_a), 32'd1);
      req = 1'b0; seed_load = 1'b1; seed_in = 11'h7FF;
      cyc();
      seed_load = 1'b0;
      chk("sl_valid", 32'(valid_a), 32'd0);
      chk("sl_busy",  32'(busy_a),  32'd0);
      chk("sl_d",     32'(u_a.u_core.d), 32'(SEED11));
      chk("sl_rnd_kept", 32'(rnd_a), 32'd3);
      m = SEED11; got = 0; req = 1'b1;
      for (int i = 0; i < 16 && got < 4; i++) begin
         cyc();
         if (valid_a) begin
            chk("sl_replay", 32'(rnd_a), 32'(m[1:0]));
            m = step11(m);
            got++;
         end
      end
      req = 1'b0;
      chk("sl_replay_count", 32'(got), 32'd4);
      cyc(); cyc();

      // reset while in HOLD
      out_ready = 1'b0; req = 1'b1;
      cyc();
      req = 1'b0;
      cyc();
      chk("rh_pre_valid", 32'(valid_a), 32'd1);
      reset = 1'b1;
      cyc();
      chk("rh_valid", 32'(valid_a), 32'd0);
      chk("rh_rnd",   32'(rnd_a),   32'd0);
      chk("rh_busy",  32'(busy_a),  32'd0);
      chk("rh_d",     32'(u_a.u_core.d), 32'(SEED11));
      reset = 1'b0;

      // reset while in DRAW
      cyc();
      req = 1'b1;
      cyc();
      chk("rd_pre_busy", 32'(busy_a), 32'd1);
      req = 1'b0; reset = 1'b1;
      cyc();
      chk("rd_valid", 32'(valid_a), 32'd0);
      chk("rd_rnd",   32'(rnd_a),   32'd0);
      chk("rd_busy",  32'(busy_a),  32'd0);
      chk("rd_d",     32'(u_a.u_core.d), 32'(SEED11));
      reset = 1'b0;

      // full period on the 11-bit generator
      m = SEED11; n = 0; err = 0; early = 0;
      out_ready = 1'b1; req = 1'b1;
      for (int cy = 0; cy < 5000 && n < 2047; cy++) begin
         cyc();
         if (valid_a) begin
            if (rnd_a !== m[1:0]) err++;
            m = step11(m);
            n++;
            if (n < 2047 && u_a.u_core.d === SEED11) early++;
         end
      end
      chk("period_draws",  32'(n),     32'd2047);
      chk("period_rnd",    32'(err),   32'd0);
      chk("period_early",  32'(early), 32'd0);
      chk("period_return", 32'(u_a.u_core.d), 32'(SEED11));

      // distribution with default parameters
      req = 1'b0; out_ready = 1'b0; reset = 1'b1;
      cyc();
      reset = 1'b0; req = 1'b1; out_ready = 1'b1;
      nd = 0;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      for (int cy = 0; cy < 45000 && nd < 20000; cy++) begin
         cyc();
         if (valid_d) begin
            cnt[rnd_d]++;
            nd++;
         end
      end
      req = 1'b0;
      chk("dist_draws", 32'(nd), 32'd20000);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("dist_bin%0d(count=%0d)", i, cnt[i]),
             32'(cnt[i] >= 4600 && cnt[i] <= 5400), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
